// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared widths, event codes and event record for the monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_STAMP_W = 8;

  typedef enum logic [1:0] {
    WRAP_UP = 2'd0,
    WRAP_DN = 2'd1,
    MATCH   = 2'd2,
    JUMP    = 2'd3
  } evt_code_e;

  typedef struct packed {
    evt_code_e                code;
    logic [DEF_STAMP_W-1:0]   stamp;
    logic [DEF_CNT_W-1:0]     cnt;
  } evt_s;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/evt_fifo.sv
// ============================================================================
// evt_fifo : synchronous FIFO of event records with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module evt_fifo
  import counter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  evt_s                   din_i,
  input  logic                   pop_i,
  output evt_s                   dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("evt_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  evt_s             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
      end
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule : evt_fifo

`default_nettype wire

// File: rtl/counter_event_monitor.sv
// ============================================================================
// counter_event_monitor : classify counter steps into timestamped, buffered events
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_event_monitor
  import counter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int STAMP_W = DEF_STAMP_W,
  parameter int DEPTH   = 4
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   chnge,
  input  logic                   cmp_en,
  input  logic [CNT_W-1:0]       cmp_val,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [1:0]             evt_code,
  output logic [STAMP_W-1:0]     evt_stamp,
  output logic [CNT_W-1:0]       evt_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf
);

  generate
    if (CNT_W != DEF_CNT_W || STAMP_W != DEF_STAMP_W) begin : g_bad_width
      $error("counter_event_monitor: widths must match the evt_s record in counter_pkg");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [CNT_W-1:0]   prev_cnt_q;
  logic               prime_q;
  logic               ovf_q, ovf_d;

  logic [CNT_W-1:0]   step_exp;
  logic               is_wrap_up, is_wrap_dn, is_match, is_jump;
  logic               evt_fire;
  evt_code_e          code;
  evt_s               evt_d, head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  always_comb begin
    step_exp   = chnge ? (prev_cnt_q + CNT_W'(1)) : (prev_cnt_q - CNT_W'(1));
    is_wrap_up = chnge  && (prev_cnt_q == CNT_MAX) && (cnt_in == '0);
    is_wrap_dn = !chnge && (prev_cnt_q == '0)      && (cnt_in == CNT_MAX);
    is_match   = cmp_en && (cnt_in == cmp_val)     && (cnt_in != prev_cnt_q);
    is_jump    = (cnt_in != prev_cnt_q) && (cnt_in != step_exp);
    evt_fire   = prime_q && (is_wrap_up || is_wrap_dn || is_match || is_jump);

    // Wraps outrank a match so a compare value of 0 or max logs only the wrap.
    if (is_wrap_up) begin
      code = WRAP_UP;
    end else if (is_wrap_dn) begin
      code = WRAP_DN;
    end else if (is_match) begin
      code = MATCH;
    end else begin
      code = JUMP;
    end

    evt_d = '{code: code, stamp: stamp_q, cnt: cnt_in};
  end

  assign pop     = evt_valid && evt_ready;
  assign push    = evt_fire && (!fifo_full || pop);
  assign stamp_d = stamp_q + STAMP_W'(1);
  assign ovf_d   = ovf_q || (evt_fire && fifo_full && !pop);

  always_ff @(posedge CLK) begin
    if (reset) begin
      stamp_q    <= '0;
      prev_cnt_q <= '0;
      prime_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      stamp_q    <= stamp_d;
      prev_cnt_q <= cnt_in;
      prime_q    <= 1'b1;
      ovf_q      <= ovf_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk     (CLK),
    .rst     (reset),
    .push_i  (push),
    .din_i   (evt_d),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_stamp = head.stamp;
  assign evt_cnt   = head.cnt;
  assign ovf       = ovf_q;

endmodule : counter_event_monitor

`default_nettype wire

// File: tb/tb_counter_event_monitor.sv
// ============================================================================
// tb_counter_event_monitor : directed self-checking bench for the event monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_event_monitor;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       chnge;
  logic       cmp_en;
  logic [3:0] cmp_val;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [7:0] evt_stamp;
  logic [3:0] evt_cnt;
  logic [2:0] fifo_level;
  logic       ovf;

  always #5 CLK = ~CLK;

  counter_event_monitor #(
    .CNT_W   (4),
    .STAMP_W (8),
    .DEPTH   (4)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .chnge      (chnge),
    .cmp_en     (cmp_en),
    .cmp_val    (cmp_val),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_stamp  (evt_stamp),
    .evt_cnt    (evt_cnt),
    .fifo_level (fifo_level),
    .ovf        (ovf)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tstamp;
  logic [7:0] stamp_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive the sample, remember the stamp it will carry, sample outputs 1ns later.
  task automatic cyc(input logic [3:0] c, input logic dir);
    cnt_in     = c;
    chnge      = dir;
    stamp_last = tstamp;
    @(posedge CLK);
    #1;
    tstamp = tstamp + 8'd1;
  endtask

  task automatic chk_head(input string tag, input logic [1:0] code,
                          input logic [3:0] cnt, input logic [7:0] st);
    chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
    chk({tag, ".code"},  32'(evt_code),  32'(code));
    chk({tag, ".cnt"},   32'(evt_cnt),   32'(cnt));
    chk({tag, ".stamp"}, 32'(evt_stamp), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st_a, st_b, st_c, st_d, st_e;
    logic [3:0] exp_cnt [4];
    logic [7:0] exp_st  [4];

    reset     = 1'b1;
    cnt_in    = 4'd5;
    chnge     = 1'b1;
    cmp_en    = 1'b0;
    cmp_val   = 4'd0;
    evt_ready = 1'b1;
    tstamp    = 8'd0;
    stamp_last = 8'd0;

    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst.valid", 32'(evt_valid),  32'd0);
    chk("rst.level", 32'(fifo_level), 32'd0);
    chk("rst.ovf",   32'(ovf),        32'd0);
    chk("rst.code",  32'(evt_code),   32'd0);
    chk("rst.stamp", 32'(evt_stamp),  32'd0);
    chk("rst.cnt",   32'(evt_cnt),    32'd0);

    // Held counter, including the priming sample: nothing logged.
    reset  = 1'b0;
    tstamp = 8'd0;
    repeat (10) cyc(4'd5, 1'b1);
    chk("hold.valid", 32'(evt_valid),  32'd0);
    chk("hold.level", 32'(fifo_level), 32'd0);
    chk("hold.ovf",   32'(ovf),        32'd0);

    // Up-count through the wrap; stamp of the 0 sample is 13.
    cyc(4'd13, 1'b1); chk_head("jump13", 2'd3, 4'd13, 8'd10);
    cyc(4'd14, 1'b1); chk("jump13.drained", 32'(fifo_level), 32'd0);
    cyc(4'd15, 1'b1); chk("up15.none", 32'(evt_valid), 32'd0);
    cyc(4'd0,  1'b1); chk_head("wrapup", 2'd0, 4'd0, 8'd13);
    chk("wrapup.level", 32'(fifo_level), 32'd1);
    cyc(4'd0,  1'b1); chk("wrapup.drained", 32'(fifo_level), 32'd0);

    // Down wrap onto the compare value: only WRAP_DN.
    cyc(4'd1, 1'b1);
    cmp_en  = 1'b1;
    cmp_val = 4'd15;
    cyc(4'd0,  1'b0); chk("down0.none", 32'(fifo_level), 32'd0);
    cyc(4'd15, 1'b0); chk_head("wrapdn15", 2'd1, 4'd15, stamp_last);
    chk("wrapdn15.level", 32'(fifo_level), 32'd1);
    cyc(4'd15, 1'b0); chk("wrapdn15.only", 32'(fifo_level), 32'd0);

    // Compare at 14: WRAP_DN then MATCH, the pop and push sharing an edge.
    cmp_val = 4'd14;
    cyc(4'd0,  1'b1); chk_head("wrapup2", 2'd0, 4'd0, stamp_last);
    cyc(4'd0,  1'b0);
    cyc(4'd15, 1'b0); chk_head("wrapdn14", 2'd1, 4'd15, stamp_last);
    cyc(4'd14, 1'b0); chk_head("match14", 2'd2, 4'd14, stamp_last);
    chk("match14.level", 32'(fifo_level), 32'd1);
    cyc(4'd14, 1'b0); chk("match14.drained", 32'(fifo_level), 32'd0);

    // Load against the count direction and a reset-to-zero are jumps.
    cmp_en = 1'b0;
    cyc(4'd4, 1'b1); chk_head("jump4", 2'd3, 4'd4, stamp_last);
    cyc(4'd4, 1'b1);
    cyc(4'd3, 1'b1); chk_head("load3", 2'd3, 4'd3, stamp_last);
    cyc(4'd3, 1'b1);
    cyc(4'd9, 1'b1);
    cyc(4'd9, 1'b1);
    cyc(4'd0, 1'b1); chk_head("reset0", 2'd3, 4'd0, stamp_last);
    cyc(4'd0, 1'b1); chk("reset0.drained", 32'(fifo_level), 32'd0);

    // Up wrap with compare value 0: wrap wins.
    cyc(4'd15, 1'b1);
    cyc(4'd15, 1'b1);
    cmp_en  = 1'b1;
    cmp_val = 4'd0;
    cyc(4'd0, 1'b1); chk_head("wrapcmp0", 2'd0, 4'd0, stamp_last);
    cyc(4'd0, 1'b1); chk("wrapcmp0.only", 32'(fifo_level), 32'd0);
    cmp_en = 1'b0;

    // Fill with the consumer stalled.
    evt_ready = 1'b0;
    cyc(4'd5,  1'b1); st_a = stamp_last;
    cyc(4'd9,  1'b1); st_b = stamp_last;
    cyc(4'd2,  1'b1); st_c = stamp_last;
    cyc(4'd12, 1'b1); st_d = stamp_last;
    chk("full.level", 32'(fifo_level), 32'd4);
    chk("full.ovf",   32'(ovf),        32'd0);
    chk_head("full.headA", 2'd3, 4'd5, st_a);

    // Full with push and pop together: accepted, no overflow.
    evt_ready = 1'b1;
    cyc(4'd3, 1'b1); st_e = stamp_last;
    chk("fullpp.level", 32'(fifo_level), 32'd4);
    chk("fullpp.ovf",   32'(ovf),        32'd0);
    chk_head("fullpp.headB", 2'd3, 4'd9, st_b);

    // Full without a pop: dropped, sticky overflow, head stays put.
    evt_ready = 1'b0;
    cyc(4'd8, 1'b1);
    chk("drop.level", 32'(fifo_level), 32'd4);
    chk("drop.ovf",   32'(ovf),        32'd1);
    cyc(4'd8, 1'b1);
    chk_head("stall.headB", 2'd3, 4'd9, st_b);

    exp_cnt[0] = 4'd9;  exp_st[0] = st_b;
    exp_cnt[1] = 4'd2;  exp_st[1] = st_c;
    exp_cnt[2] = 4'd12; exp_st[2] = st_d;
    exp_cnt[3] = 4'd3;  exp_st[3] = st_e;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("drain%0d", i), 2'd3, exp_cnt[i], exp_st[i]);
      cyc(4'd8, 1'b1);
    end
    chk("drained.valid", 32'(evt_valid),  32'd0);
    chk("drained.level", 32'(fifo_level), 32'd0);
    cyc(4'd8, 1'b1);
    chk("empty.noudf", 32'(fifo_level), 32'd0);
    chk("empty.ovf",   32'(ovf),        32'd1);

    // Reset with three events buffered.
    evt_ready = 1'b0;
    cyc(4'd2,  1'b1);
    cyc(4'd10, 1'b1);
    cyc(4'd4,  1'b1);
    chk("pre_rst.level", 32'(fifo_level), 32'd3);
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("midrst.valid", 32'(evt_valid),  32'd0);
    chk("midrst.level", 32'(fifo_level), 32'd0);
    chk("midrst.ovf",   32'(ovf),        32'd0);
    reset     = 1'b0;
    tstamp    = 8'd0;
    evt_ready = 1'b1;
    cyc(4'd6, 1'b1);
    chk("prime.valid", 32'(evt_valid),  32'd0);
    chk("prime.level", 32'(fifo_level), 32'd0);
    cyc(4'd11, 1'b1); chk_head("post_rst", 2'd3, 4'd11, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_counter_event_monitor

`default_nettype wire
